// File: rtl/serial_pkg.sv
// Shared definitions for the serial TX path (and the future RX path).
package serial_pkg;

    // Line protocol state, shared by transmitter and receiver.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } serial_state_t;

    localparam int unsigned FRAME_DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W       = 3;
    localparam int unsigned WORD_W          = 32;

    typedef logic [FRAME_DATA_BITS-1:0] serial_data_t;

    // Clock cycles per line bit, truncated; callers keep the result >= 2.
    function automatic int unsigned calc_div(input int unsigned clock_frequency,
                                             input int unsigned baud_rate);
        return clock_frequency / baud_rate;
    endfunction

    // Bits needed to hold 0..div-1, never less than one.
    function automatic int unsigned calc_count_width(input int unsigned div);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(div)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_output_baud_counter.sv
// Free-running bit-period counter: counts 0..DIV-1 and flags the last cycle.
module baud_counter
    import serial_pkg::*;
#(
    parameter int unsigned DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = calc_count_width(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Advance, wrapping at the end of a bit period or on an explicit restart.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (restart || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/serial_output.sv
// RS-232 transmitter: takes words over stb/ack and sends the low byte as 8N1, LSB first.
module serial_output
    import serial_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int unsigned BAUD_RATE       = 115200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] input_in,
    input  logic              input_in_stb,
    output logic              input_in_ack,
    output logic              tx,
    output logic              busy
);

    localparam int unsigned DIV = calc_div(CLOCK_FREQUENCY, BAUD_RATE);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(FRAME_DATA_BITS - 1);

    serial_state_t          state_q;
    serial_state_t          state_d;
    logic                   tx_q;
    logic                   tx_d;
    logic                   ack_q;
    logic                   ack_d;
    serial_data_t           shift_q;
    serial_data_t           shift_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q;
    logic [BIT_IDX_W-1:0]   bit_idx_d;

    logic                   bit_done;
    logic                   restart;
    logic                   xfer;
    logic                   unused_upper;

    // Only the low byte goes on the line.
    assign unused_upper = ^input_in[WORD_W-1:FRAME_DATA_BITS];

    // Ack is only ever high in IDLE, so this alone marks a transfer edge.
    assign xfer    = input_in_stb && ack_q;
    assign restart = (state_q == IDLE);

    baud_counter #(
        .DIV (DIV)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (bit_done)
    );

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            ack_q     <= 1'b0;
            shift_q   <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            ack_q     <= ack_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // Frame sequencing: start, eight data bits, stop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done && (bit_idx_q == LAST_BIT)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level, handshake and shifter updates for the next cycle.
    always_comb begin
        tx_d      = tx_q;
        ack_d     = ack_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            IDLE: begin
                bit_idx_d = '0;
                if (xfer) begin
                    shift_d = input_in[FRAME_DATA_BITS-1:0];
                    ack_d   = 1'b0;
                    tx_d    = 1'b0;
                end else begin
                    ack_d   = 1'b1;
                    tx_d    = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[FRAME_DATA_BITS-1:1]};
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == LAST_BIT) begin
                        tx_d = 1'b1;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[FRAME_DATA_BITS-1:1]};
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    ack_d = 1'b1;
                end
            end
            default: begin
                tx_d  = 1'b1;
                ack_d = 1'b0;
            end
        endcase
    end

    assign tx           = tx_q;
    assign input_in_ack = ack_q;
    assign busy         = (state_q != IDLE);

endmodule
